// File: rtl/rx_data_packer.sv
// Receive-side packer: hard-decision bits to 32-bit words, MSB-first,
// written sequentially into the receive data RAM, one slot at a time.
module rx_data_packer #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slot_start,
  input  logic [31:0]       fh_num,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [ADDR_W-1:0] rx_data_ram_addr,
  output logic [WORD_W-1:0] rx_data_ram_data,
  output logic              rx_data_ram_wr,
  output logic              ram_switch,
  output logic              slot_done,
  output logic [ADDR_W:0]   words_written,
  output logic              overrun
);

  localparam int FILL_W = $clog2(WORD_W);
  localparam int CNT_W  = ADDR_W + FILL_W + 1;
  localparam logic [CNT_W-1:0] MAX_BITS = CNT_W'(1) << (CNT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FLUSH,
    DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  target_q;
  logic [CNT_W-1:0]  bitcnt_q;
  logic [WORD_W-1:0] shreg_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [WORD_W-1:0] ram_data_q;
  logic              ram_wr_q;
  logic              switch_q;
  logic              done_q;
  logic [ADDR_W:0]   words_q;
  logic              overrun_q;

  logic [CNT_W-1:0]  target_d;
  logic [WORD_W-1:0] shreg_d;
  logic [FILL_W-1:0] fill;
  logic              word_end;
  logic              last_bit;

  assign fill     = bitcnt_q[FILL_W-1:0];
  assign word_end = &fill;
  assign last_bit = (bitcnt_q + CNT_W'(1)) == target_q;
  assign target_d = (fh_num > 32'(MAX_BITS)) ? MAX_BITS
                                             : fh_num[CNT_W-1:0];

  // Bits land directly at their final position, so a partial word is
  // already left-justified with zero LSBs.
  always_comb begin
    shreg_d       = shreg_q;
    shreg_d[~fill] = bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      addr_q     <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wr_q   <= 1'b0;
      switch_q   <= 1'b0;
      done_q     <= 1'b0;
      words_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      ram_wr_q <= 1'b0;
      done_q   <= 1'b0;
      if (bit_valid && state_q != COLLECT) begin
        overrun_q <= 1'b1;
      end
      if (slot_start) begin
        target_q  <= target_d;
        bitcnt_q  <= '0;
        shreg_q   <= '0;
        addr_q    <= '0;
        words_q   <= '0;
        overrun_q <= 1'b0;
        state_q   <= (target_d == '0) ? DONE : COLLECT;
      end else begin
        unique case (state_q)
          IDLE: ;
          COLLECT: begin
            if (bit_valid) begin
              bitcnt_q <= bitcnt_q + CNT_W'(1);
              if (word_end || last_bit) begin
                ram_wr_q   <= 1'b1;
                ram_data_q <= shreg_d;
                ram_addr_q <= addr_q;
                addr_q     <= addr_q + ADDR_W'(1);
                words_q    <= words_q + (ADDR_W+1)'(1);
                shreg_q    <= '0;
              end else begin
                shreg_q <= shreg_d;
              end
              if (last_bit) begin
                state_q <= word_end ? DONE : FLUSH;
              end
            end
          end
          // FLUSH marks the cycle the padded write is on the port.
          FLUSH, DONE: begin
            done_q   <= 1'b1;
            switch_q <= ~switch_q;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_data_ram_addr = ram_addr_q;
  assign rx_data_ram_data = ram_data_q;
  assign rx_data_ram_wr   = ram_wr_q;
  assign ram_switch       = switch_q;
  assign slot_done        = done_q;
  assign words_written    = words_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_rx_data_packer.sv
// Scoreboard bench for rx_data_packer: expected RAM writes are queued as
// bits are driven and retired as the write port fires.
module tb_rx_data_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        slot_start;
  logic [31:0] fh_num;
  logic        bit_in;
  logic        bit_valid;
  logic [7:0]  rx_data_ram_addr;
  logic [31:0] rx_data_ram_data;
  logic        rx_data_ram_wr;
  logic        ram_switch;
  logic        slot_done;
  logic [8:0]  words_written;
  logic        overrun;

  rx_data_packer dut (
    .clk              (clk),
    .rst              (rst),
    .slot_start       (slot_start),
    .fh_num           (fh_num),
    .bit_in           (bit_in),
    .bit_valid        (bit_valid),
    .rx_data_ram_addr (rx_data_ram_addr),
    .rx_data_ram_data (rx_data_ram_data),
    .rx_data_ram_wr   (rx_data_ram_wr),
    .ram_switch       (ram_switch),
    .slot_done        (slot_done),
    .words_written    (words_written),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = -1;
  int  last_cyc = -1;
  int  start_cyc = -1;
  logic exp_sw = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_data_ram_wr) begin
        if (q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          wr_t e;
          e = q.pop_front();
          check("wr_addr", rx_data_ram_addr, e.a);
          check("wr_data", rx_data_ram_data, e.d);
        end
      end
      if (slot_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic slot(input int fh, input int nbits, input bit gaps);
    int tgt, cnt, adr;
    logic [31:0] w;
    tgt = (fh > 8192) ? 8192 : fh;
    cnt = 0;
    adr = 0;
    w = '0;
    @(posedge clk); #1;
    fh_num = fh;
    slot_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    slot_start = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        bit_valid = 1'b0;
        @(posedge clk); #1;
      end
      bit_valid = 1'b1;
      bit_in = 1'($urandom_range(0, 1));
      if (cnt < tgt) begin
        w[31 - (cnt % 32)] = bit_in;
        cnt++;
        if (cnt % 32 == 0 || cnt == tgt) begin
          q.push_back({8'(adr), w});
          adr++;
          w = '0;
        end
        if (cnt == tgt) last_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_cnt, input int ref_cyc);
    int k;
    k = 0;
    while (done_cnt < exp_cnt && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < exp_cnt) begin
      check("done_timeout", 0, 1);
    end else begin
      check("done_lat", done_cyc, ref_cyc + 2);
      exp_sw = ~exp_sw;
    end
    @(negedge clk);
    check("switch", ram_switch, exp_sw);
    check("q_drained", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    slot_start = 1'b0;
    fh_num = '0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_addr", rx_data_ram_addr, 0);
    check("rst_data", rx_data_ram_data, 0);
    check("rst_wr", rx_data_ram_wr, 0);
    check("rst_switch", ram_switch, 0);
    check("rst_done", slot_done, 0);
    check("rst_words", words_written, 0);
    check("rst_ovr", overrun, 0);

    slot(904, 904, 1'b0);
    wait_done(1, last_cyc);
    check("dflt_words", words_written, 29);
    check("dflt_ovr", overrun, 0);

    slot(64, 64, 1'b1);
    wait_done(2, last_cyc);
    check("mult_words", words_written, 2);

    slot(10000, 10000, 1'b0);
    wait_done(3, last_cyc);
    check("clip_words", words_written, 256);
    check("clip_ovr", overrun, 1);

    slot(904, 40, 1'b0);
    slot(904, 904, 1'b0);
    check("abort_nodone", done_cnt, 3);
    wait_done(4, last_cyc);
    check("abort_words", words_written, 29);

    slot(0, 0, 1'b0);
    wait_done(5, start_cyc);
    check("zero_words", words_written, 0);
    check("zero_ovr", overrun, 0);

    slot(904, 100, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_sw = 1'b0;
    @(negedge clk);
    check("mrst_wr", rx_data_ram_wr, 0);
    check("mrst_addr", rx_data_ram_addr, 0);
    check("mrst_data", rx_data_ram_data, 0);
    check("mrst_switch", ram_switch, 0);
    check("mrst_words", words_written, 0);
    check("mrst_ovr", overrun, 0);
    repeat (40) @(negedge clk);
    check("mrst_nodone", done_cnt, 5);
    check("mrst_switch2", ram_switch, exp_sw);
    check("mrst_q", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_data_packer.md
# rx_data_packer

Receive-side writer for the receive data memory. Collects demodulated hard-decision bits for one timeslot, packs them MSB-first into 32-bit words, and writes them sequentially into the 256 x 32 receive data RAM through its addr/data/wr port. At slot end it flushes any partial word, toggles `ram_switch` and pulses `slot_done` so the DSP-side reader can fetch the slot. The bit count per slot comes from the `fh_num` register, 904 in the current build.

## Interface
- `WORD_W`, 32: packed word width; fixed, not to be overridden.
- `ADDR_W`, 8: RAM address width; capacity is 2^ADDR_W words.
- `clk`  in  1  system clock, 200 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `slot_start`  in  1  one-cycle pulse that starts or restarts slot collection.
- `fh_num`  in  32  bits per slot; sampled only on `slot_start`.
- `bit_in`  in  1  demodulated data bit.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `rx_data_ram_addr`  out  8  RAM write address.
- `rx_data_ram_data`  out  32  RAM write data.
- `rx_data_ram_wr`  out  1  RAM write enable, one cycle per word.
- `ram_switch`  out  1  buffer select; toggles once per completed slot.
- `slot_done`  out  1  one-cycle pulse when a slot has been fully written.
- `words_written`  out  9  words written in the current or last slot, 0..256.
- `overrun`  out  1  sticky flag; set by `bit_valid` outside COLLECT, cleared by `rst` or `slot_start`.

## Operation
- **States:** IDLE, COLLECT, FLUSH, DONE.
- **IDLE:**
  - `slot_start` latches `target = min(fh_num, 8192)`.
  - It clears the bit counter, shift register, word address and `words_written`, then goes to COLLECT.
  - If `target == 0`, it goes to DONE instead.
- **COLLECT:**
  - Each `bit_valid` shifts `bit_in` into a 32-bit shift register, first bit ending in bit 31, and increments the bit counter.
  - After the 32nd bit of a word, the packed word is written on the next cycle at the current word address. The address then increments and the shift state clears.
  - When the bit counter reaches `target`:
    - If the word is partial, go to FLUSH. The partial word is left-justified; unfilled LSBs are 0.
    - If the word boundary coincides with `target`, the full-word write happens and the block goes to DONE with no extra write.
- **FLUSH:** issue one write of the padded partial word, then go to DONE.
- **DONE:** pulse `slot_done` for one cycle, toggle `ram_switch` in the same cycle, then go to IDLE.
- **Abort:** `slot_start` while in COLLECT, FLUSH or DONE restarts the slot as in IDLE.
  - The partial word is discarded and no pending flush write is issued.
  - No `slot_done` pulse occurs and `ram_switch` does not toggle.
  - A write already presented in the same cycle completes.
- **Simultaneous final bit and `slot_start`:** restart wins and the final bit is discarded.
- **`bit_valid` in IDLE or DONE:** ignored and sets `overrun`.
- **Address range:** the address never wraps within a slot; the 8192-bit clip guarantees at most 256 writes (addr 0..255).
- **`words_written`:** increments on each write and holds after DONE until the next `slot_start`.

## Timing
- **Reset:** all outputs are 0 (`ram_switch = 0`, `slot_done = 0`, `rx_data_ram_wr = 0`, addr/data 0, `words_written = 0`, `overrun = 0`); state is IDLE.
- **Write latency:** the bit completing a word is accepted in cycle N; `rx_data_ram_wr`, `rx_data_ram_data` and `rx_data_ram_addr` are registered and valid in cycle N+1.
- **Slot end, full final word:** last bit in cycle N, write in N+1, `slot_done` and `ram_switch` toggle in N+2.
- **Slot end, partial final word:** last bit in cycle N, FLUSH write in N+1, `slot_done` in N+2.
- **Zero-length slot:** `fh_num = 0` gives `slot_done` 2 cycles after `slot_start`, with no write.
- **Throughput:** one bit per cycle sustained; `bit_valid` may gap arbitrarily with no effect on packing.
- **Back-to-back slots:** `slot_start` is accepted again in the cycle after DONE, or as an abort at any time.
- **Reset mid-slot:** returns to IDLE within one cycle; no write or `slot_done` follows.

## Test plan
- **Default slot:** `fh_num = 904`, 904 random bits at full rate.
  - Required: 29 writes at addr 0..28; words 0..27 match the stream MSB-first.
  - Word 28 holds the last 8 bits in [31:24] with [23:0] = 0.
  - `slot_done` comes 2 cycles after the last bit; `ram_switch` goes 0->1; `words_written = 29`.
- **Exact multiple:** `fh_num = 64`, bits with random `bit_valid` gaps.
  - Required: exactly 2 writes (addr 0, 1) and no padding write; `slot_done` 2 cycles after the 64th bit.
- **Clip:** `fh_num = 10000`, 10000 bits.
  - Required: 256 writes at addr 0..255 with no wrap; the remaining bits set `overrun`; `words_written = 256`.
- **Abort:** `slot_start` after 40 bits of a 904-bit slot, then a full 904-bit slot.
  - Required: exactly one write before the abort (addr 0).
  - The restarted slot writes from addr 0; `ram_switch` toggles once in total.
- **Zero length:** `fh_num = 0`.
  - Required: no writes; `slot_done` 2 cycles after `slot_start`; `ram_switch` toggles.
- **Reset mid-slot:** `rst` after 100 bits.
  - Required: all outputs 0 the next cycle, with no further writes or `slot_done` until a new `slot_start`.
